// File: rtl/decode_operand_fetch_pkg.sv
// Shared definitions for the decode/operand-fetch stage:
// field layout, opcodes, control encodings and helpers.
package decode_operand_fetch_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int PC_W   = 8;
    localparam int IMM_W  = 15;
    localparam int NREGS  = 32;
    localparam int OP_W   = 7;
    localparam int FS_W   = 5;

    localparam int OP_LSB = 25;
    localparam int DR_LSB = 20;
    localparam int SA_LSB = 15;
    localparam int SB_LSB = 10;
    localparam int IM_LSB = 0;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    typedef enum logic [1:0] {
        MD_ALU  = 2'b00,
        MD_MEM  = 2'b01,
        MD_FLAG = 2'b10
    } md_e;

    typedef enum logic [1:0] {
        BS_NONE = 2'b00,
        BS_BZ   = 2'b01,
        BS_BNZ  = 2'b10,
        BS_JMP  = 2'b11
    } bs_e;

    localparam logic [FS_W-1:0] FS_PASSA = 5'b00000;
    localparam logic [FS_W-1:0] FS_INC   = 5'b00001;
    localparam logic [FS_W-1:0] FS_ADD   = 5'b00010;
    localparam logic [FS_W-1:0] FS_SUB   = 5'b00101;
    localparam logic [FS_W-1:0] FS_DEC   = 5'b00110;
    localparam logic [FS_W-1:0] FS_NEG   = 5'b00111;
    localparam logic [FS_W-1:0] FS_AND   = 5'b01000;
    localparam logic [FS_W-1:0] FS_OR    = 5'b01010;
    localparam logic [FS_W-1:0] FS_XOR   = 5'b01100;
    localparam logic [FS_W-1:0] FS_NOT   = 5'b01110;
    localparam logic [FS_W-1:0] FS_SHR   = 5'b10100;
    localparam logic [FS_W-1:0] FS_ASR   = 5'b10101;
    localparam logic [FS_W-1:0] FS_ROR   = 5'b10110;
    localparam logic [FS_W-1:0] FS_SHL   = 5'b11000;
    localparam logic [FS_W-1:0] FS_ROL   = 5'b11001;

    localparam logic [OP_W-1:0] OP_NOP = 7'b0000000;
    localparam logic [OP_W-1:0] OP_MOV = 7'b1000000;
    localparam logic [OP_W-1:0] OP_ADD = 7'b0000010;
    localparam logic [OP_W-1:0] OP_SUB = 7'b0000101;
    localparam logic [OP_W-1:0] OP_AND = 7'b0001000;
    localparam logic [OP_W-1:0] OP_OR  = 7'b0001001;
    localparam logic [OP_W-1:0] OP_XOR = 7'b0001010;
    localparam logic [OP_W-1:0] OP_NOT = 7'b0101110;
    localparam logic [OP_W-1:0] OP_ADI = 7'b0100010;
    localparam logic [OP_W-1:0] OP_SBI = 7'b0100101;
    localparam logic [OP_W-1:0] OP_ANI = 7'b0101000;
    localparam logic [OP_W-1:0] OP_ORI = 7'b0101001;
    localparam logic [OP_W-1:0] OP_XRI = 7'b0101010;
    localparam logic [OP_W-1:0] OP_AIU = 7'b1100010;
    localparam logic [OP_W-1:0] OP_SIU = 7'b1000101;
    localparam logic [OP_W-1:0] OP_LD  = 7'b0100001;
    localparam logic [OP_W-1:0] OP_ST  = 7'b0000001;
    localparam logic [OP_W-1:0] OP_LSL = 7'b0110000;
    localparam logic [OP_W-1:0] OP_LSR = 7'b0110001;
    localparam logic [OP_W-1:0] OP_ASR = 7'b0110010;
    localparam logic [OP_W-1:0] OP_ROL = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ROR = 7'b0110100;
    localparam logic [OP_W-1:0] OP_INC = 7'b0000011;
    localparam logic [OP_W-1:0] OP_DEC = 7'b0000110;
    localparam logic [OP_W-1:0] OP_NEG = 7'b0000100;
    localparam logic [OP_W-1:0] OP_JMR = 7'b1100001;
    localparam logic [OP_W-1:0] OP_SLT = 7'b1100101;
    localparam logic [OP_W-1:0] OP_BZ  = 7'b0100000;
    localparam logic [OP_W-1:0] OP_BNZ = 7'b1100000;
    localparam logic [OP_W-1:0] OP_JMP = 7'b1000100;
    localparam logic [OP_W-1:0] OP_JML = 7'b0000111;

    typedef struct packed {
        logic            valid;
        logic            rw;
        md_e             md;
        bs_e             bs;
        logic            ps;
        logic            mw;
        logic [FS_W-1:0] fs;
        logic            mb;
        logic            ma;
        logic            cs;
        logic            use_a;
        logic            use_b;
    } ctrl_t;

    typedef struct packed {
        logic [PC_W-1:0]   pc_2;
        logic [PC_W-1:0]   bra;
        logic [DATA_W-1:0] bus_a;
        logic [DATA_W-1:0] bus_b;
        logic [REG_AW-1:0] dr;
        logic              rw;
        logic              mw;
        logic              ps;
        md_e               md;
        bs_e               bs;
        logic [FS_W-1:0]   fs;
    } dof_ex_t;

    function automatic ctrl_t cw(
        input logic            rw,
        input md_e             md,
        input bs_e             bs,
        input logic            ps,
        input logic            mw,
        input logic [FS_W-1:0] fs,
        input logic            mb,
        input logic            ma,
        input logic            cs,
        input logic            ua,
        input logic            ub
    );
        return '{1'b1, rw, md, bs, ps, mw, fs, mb, ma, cs, ua, ub};
    endfunction

    function automatic logic [DATA_W-1:0] ext_imm(
        input logic [IMM_W-1:0] im,
        input logic             cs
    );
        return cs ? {{(DATA_W-IMM_W){im[IMM_W-1]}}, im}
                  : {{(DATA_W-IMM_W){1'b0}}, im};
    endfunction

endpackage

// File: rtl/decode_operand_fetch_regfile.sv
// 32x32 register file: two async read ports with write-through,
// one sync write port, sync clear, R0 reads as zero.
module decode_operand_fetch_regfile
    import decode_operand_fetch_pkg::*;
(
    input  logic              CLK,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] ra_a,
    input  logic [REG_AW-1:0] ra_b,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b
);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];
    logic              wr_ok;

    assign wr_ok = we && (waddr != '0);

    assign rd_a = (ra_a == '0)              ? '0    :
                  (wr_ok && waddr == ra_a)  ? wdata :
                  mem_q[ra_a];

    assign rd_b = (ra_b == '0)              ? '0    :
                  (wr_ok && waddr == ra_b)  ? wdata :
                  mem_q[ra_b];

    // Next contents: at most one write per cycle, R0 never written
    always_comb begin
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[waddr] = wdata;
        end
    end

    // Register array update with synchronous clear
    always_ff @(posedge CLK) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/decode_operand_fetch.sv
// Decode/operand-fetch stage: decodes IR, reads operands,
// detects RAW hazards against execute, registers the bundle.
module decode_operand_fetch
    import decode_operand_fetch_pkg::*;
(
    input  logic              CLK,
    input  logic              reset,
    input  logic [31:0]       IR_in,
    input  logic [PC_W-1:0]   PC_1_in,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_rw,
    input  logic [REG_AW-1:0] ex_dr,
    output logic              stall,
    output logic [PC_W-1:0]   PC_2,
    output logic [PC_W-1:0]   BrA,
    output logic [DATA_W-1:0] BUS_A,
    output logic [DATA_W-1:0] BUS_B,
    output logic [REG_AW-1:0] DR,
    output logic              RW,
    output logic              MW,
    output logic              PS,
    output logic [1:0]        MD,
    output logic [1:0]        BS,
    output logic [FS_W-1:0]   FS
);

    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] dr;
    logic [REG_AW-1:0] sa;
    logic [REG_AW-1:0] sb;
    logic [IMM_W-1:0]  im;
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] k_val;
    logic [DATA_W-1:0] bus_a;
    logic [DATA_W-1:0] bus_b;
    logic              haz_a;
    logic              haz_b;
    logic              hazard;
    ctrl_t             ctrl;
    dof_ex_t           ex_d;
    dof_ex_t           ex_q;

    assign opcode = IR_in[OP_LSB +: OP_W];
    assign dr     = IR_in[DR_LSB +: REG_AW];
    assign sa     = IR_in[SA_LSB +: REG_AW];
    assign sb     = IR_in[SB_LSB +: REG_AW];
    assign im     = IR_in[IM_LSB +: IMM_W];

    decode_operand_fetch_regfile u_rf (
        .CLK   (CLK),
        .reset (reset),
        .we    (wb_en),
        .waddr (wb_addr),
        .wdata (wb_data),
        .ra_a  (sa),
        .ra_b  (sb),
        .rd_a  (reg_a),
        .rd_b  (reg_b)
    );

    // Opcode to control word; anything unlisted (incl. NOP) is a bubble
    always_comb begin
        ctrl = '0;
        unique case (opcode)
            OP_MOV: ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_PASSA, N, N, N, Y, N);
            OP_ADD: ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_ADD, N, N, N, Y, Y);
            OP_SUB: ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_SUB, N, N, N, Y, Y);
            OP_AND: ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_AND, N, N, N, Y, Y);
            OP_OR:  ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_OR, N, N, N, Y, Y);
            OP_XOR: ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_XOR, N, N, N, Y, Y);
            OP_NOT: ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_NOT, N, N, N, Y, N);
            OP_INC: ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_INC, N, N, N, Y, N);
            OP_DEC: ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_DEC, N, N, N, Y, N);
            OP_NEG: ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_NEG, N, N, N, Y, N);
            OP_ADI: ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_ADD, Y, N, Y, Y, N);
            OP_SBI: ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_SUB, Y, N, Y, Y, N);
            OP_ANI: ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_AND, Y, N, N, Y, N);
            OP_ORI: ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_OR, Y, N, N, Y, N);
            OP_XRI: ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_XOR, Y, N, N, Y, N);
            OP_AIU: ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_ADD, Y, N, N, Y, N);
            OP_SIU: ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_SUB, Y, N, N, Y, N);
            OP_LSL: ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_SHL, Y, N, N, Y, N);
            OP_LSR: ctrl = cw(Y, MD_ALU, BS_NONE, Y, N, FS_SHR, Y, N, N, Y, N);
            OP_ASR: ctrl = cw(Y, MD_ALU, BS_NONE, Y, N, FS_ASR, Y, N, N, Y, N);
            OP_ROL: ctrl = cw(Y, MD_ALU, BS_NONE, N, N, FS_ROL, Y, N, N, Y, N);
            OP_ROR: ctrl = cw(Y, MD_ALU, BS_NONE, Y, N, FS_ROR, Y, N, N, Y, N);
            OP_LD:  ctrl = cw(Y, MD_MEM, BS_NONE, N, N, FS_PASSA, N, N, N, Y, N);
            OP_ST:  ctrl = cw(N, MD_ALU, BS_NONE, N, Y, FS_PASSA, N, N, N, Y, Y);
            OP_SLT: ctrl = cw(Y, MD_FLAG, BS_NONE, N, N, FS_SUB, N, N, N, Y, Y);
            OP_JMR: ctrl = cw(N, MD_ALU, BS_JMP, N, N, FS_PASSA, N, N, N, Y, N);
            OP_BZ:  ctrl = cw(N, MD_ALU, BS_BZ, N, N, FS_PASSA, Y, N, Y, Y, N);
            OP_BNZ: ctrl = cw(N, MD_ALU, BS_BNZ, Y, N, FS_PASSA, Y, N, Y, Y, N);
            OP_JMP: ctrl = cw(N, MD_ALU, BS_JMP, N, N, FS_PASSA, Y, N, Y, N, N);
            OP_JML: ctrl = cw(Y, MD_ALU, BS_JMP, N, N, FS_PASSA, Y, Y, Y, N, N);
            default: ctrl = '0;
        endcase
    end

    assign k_val = ext_imm(im, ctrl.cs);
    assign bus_a = ctrl.ma ? {{(DATA_W-PC_W){1'b0}}, PC_1_in} : reg_a;
    assign bus_b = ctrl.mb ? k_val : reg_b;

    assign haz_a  = ctrl.use_a && !ctrl.ma && (ex_dr == sa);
    assign haz_b  = ctrl.use_b && !ctrl.mb && (ex_dr == sb);
    assign hazard = ex_rw && (ex_dr != '0) && (haz_a || haz_b);
    assign stall  = hazard && !flush;

    // Next stage word: bubble on flush, hazard or non-instruction
    always_comb begin
        ex_d = '0;
        if (ctrl.valid && !flush && !hazard) begin
            ex_d.pc_2  = PC_1_in;
            ex_d.bra   = PC_1_in + im[PC_W-1:0];
            ex_d.bus_a = bus_a;
            ex_d.bus_b = bus_b;
            ex_d.dr    = ctrl.rw ? dr : '0;
            ex_d.rw    = ctrl.rw;
            ex_d.mw    = ctrl.mw;
            ex_d.ps    = ctrl.ps;
            ex_d.md    = ctrl.md;
            ex_d.bs    = ctrl.bs;
            ex_d.fs    = ctrl.fs;
        end
    end

    // Pipeline register toward execute
    always_ff @(posedge CLK) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign PC_2  = ex_q.pc_2;
    assign BrA   = ex_q.bra;
    assign BUS_A = ex_q.bus_a;
    assign BUS_B = ex_q.bus_b;
    assign DR    = ex_q.dr;
    assign RW    = ex_q.rw;
    assign MW    = ex_q.mw;
    assign PS    = ex_q.ps;
    assign MD    = ex_q.md;
    assign BS    = ex_q.bs;
    assign FS    = ex_q.fs;

endmodule
